// File: rtl/fib_tim_sequencer.sv
// Control sequencer for the Fibonacci and countdown timer datapaths: start/stop/update
// pulses become clear strobes, rate-divided step enables and a display-source grant.
module fib_tim_sequencer #(
    parameter int unsigned BASE_DIV = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_f,
    input  logic       start_t,
    input  logic       stop_f_t,
    input  logic       update,
    input  logic [2:0] prog,
    input  logic       fib_done,
    input  logic       tim_done,
    output logic       clr_fib,
    output logic       clr_tim,
    output logic       en_fib,
    output logic       en_tim,
    output logic [1:0] sel_disp,
    output logic [2:0] prog_q,
    output logic [5:0] led
);

    localparam int unsigned PROG_W = 3;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR_F = 3'd1,
        CLR_T = 3'd2,
        FIB   = 3'd3,
        TIM   = 3'd4,
        HOLD  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PROG_W-1:0]  prog_d;
    logic               clr_fib_q, clr_fib_d;
    logic               clr_tim_q, clr_tim_d;
    logic               en_fib_q, en_fib_d;
    logic               en_tim_q, en_tim_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [5:0]         led_q, led_d;
    logic [CNT_W-1:0]   period_m1;
    logic               run, stay, terminal;
    logic [2:0]         state_oh;

    // Next state, divider and registered strobe/display values
    always_comb begin
        state_d   = state_q;
        prog_d    = prog_q;
        cnt_d     = '0;
        clr_fib_d = 1'b0;
        clr_tim_d = 1'b0;
        en_fib_d  = 1'b0;
        en_tim_d  = 1'b0;
        sel_d     = sel_q;
        state_oh  = 3'b001;

        case (state_q)
            IDLE, HOLD: begin
                if (start_f)      state_d = CLR_F;
                else if (start_t) state_d = CLR_T;
            end
            CLR_F:   state_d = FIB;
            CLR_T:   state_d = TIM;
            FIB:     if (stop_f_t || fib_done) state_d = HOLD;
            TIM:     if (stop_f_t || tim_done) state_d = HOLD;
            default: state_d = IDLE;
        endcase

        if (update) prog_d = prog;

        // Divider only runs while staying in FIB/TIM; an update restarts the period
        period_m1 = (CNT_W'(BASE_DIV) << prog_q) - CNT_W'(1);
        run       = (state_q == FIB) || (state_q == TIM);
        stay      = (state_d == state_q);
        terminal  = run && (cnt_q == period_m1);
        if (run && stay && !update && !terminal) cnt_d = cnt_q + CNT_W'(1);
        en_fib_d  = terminal && stay && !update && (state_q == FIB);
        en_tim_d  = terminal && stay && !update && (state_q == TIM);

        clr_fib_d = (state_d == CLR_F);
        clr_tim_d = (state_d == CLR_T);

        case (state_d)
            IDLE:       begin sel_d = 2'd0; state_oh = 3'b001; end
            CLR_F, FIB: begin sel_d = 2'd1; state_oh = 3'b010; end
            CLR_T, TIM: begin sel_d = 2'd2; state_oh = 3'b100; end
            HOLD:       begin sel_d = sel_q; state_oh = 3'b011; end
            default:    begin sel_d = 2'd0; state_oh = 3'b001; end
        endcase
        led_d = {state_oh, prog_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prog_q    <= '0;
            cnt_q     <= '0;
            clr_fib_q <= 1'b0;
            clr_tim_q <= 1'b0;
            en_fib_q  <= 1'b0;
            en_tim_q  <= 1'b0;
            sel_q     <= '0;
            led_q     <= 6'b001_000;
        end else begin
            state_q   <= state_d;
            prog_q    <= prog_d;
            cnt_q     <= cnt_d;
            clr_fib_q <= clr_fib_d;
            clr_tim_q <= clr_tim_d;
            en_fib_q  <= en_fib_d;
            en_tim_q  <= en_tim_d;
            sel_q     <= sel_d;
            led_q     <= led_d;
        end
    end

    assign clr_fib  = clr_fib_q;
    assign clr_tim  = clr_tim_q;
    assign en_fib   = en_fib_q;
    assign en_tim   = en_tim_q;
    assign sel_disp = sel_q;
    assign led      = led_q;

endmodule
